// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the core's mem_bus master and the SRAM slave.
// No latency of its own; carries the five AXI channels unchanged.
// Backpressure travels on each channel's ready/valid pair.
interface axi_sram_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  // read address
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [31:0]             araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  // read data
  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  // write address
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [31:0]             awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  // write data
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  // write response
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a single-port synchronous SRAM; one burst in flight, R/W round-robin.
// Latency: AR/AW accepted >=1 cycle after valid; read beat every 2 cycles; write beat per cycle.
// Backpressure: R/B outputs held until ready; W stalled (wready=0) outside the data phase.
module axi_sram_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_sram_slave_if.slave         s,
  output logic                    sram_en,
  output logic [DATA_WIDTH/8-1:0] sram_we,
  output logic [MEM_AW-1:0]       sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t              state_q, state_d;
  logic                arready_q, arready_d;
  logic                awready_q, awready_d;
  logic                rr_last_wr_q, rr_last_wr_d;  // 1: last completed transaction was a write
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;
  logic                werr_q, werr_d;

  logic                ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic                last_beat;
  logic [31:0]         step, wrap_mask, next_addr;

  // Unsupported size, reserved burst type or a WRAP length AXI does not allow.
  function automatic logic bad_req(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  assign ar_hs     = s.arvalid && arready_q;
  assign aw_hs     = s.awvalid && awready_q;
  assign r_hs      = (state_q == RD_DATA) && s.rready;
  assign w_hs      = (state_q == WR_DATA) && s.wvalid;
  assign b_hs      = (state_q == WR_RESP) && s.bready;
  assign last_beat = (beat_cnt_q == len_q);

  // Address of the following beat for FIXED / INCR / WRAP bursts.
  always_comb begin
    step      = 32'd1 << size_q;
    wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = addr_q + step;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: next_addr = addr_q;
    endcase
  end

  // Next-state logic: arbitration in IDLE, beat sequencing in the data phases.
  always_comb begin
    state_d      = state_q;
    arready_d    = 1'b0;
    awready_d    = 1'b0;
    rr_last_wr_d = rr_last_wr_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    werr_d       = werr_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d    = RD_REQ;
          id_d       = s.arid;
          addr_d     = s.araddr;
          len_d      = s.arlen;
          size_d     = s.arsize;
          burst_d    = s.arburst;
          beat_cnt_d = 8'd0;
          err_d      = bad_req(s.arlen, s.arsize, s.arburst);
        end else if (aw_hs) begin
          state_d    = WR_DATA;
          id_d       = s.awid;
          addr_d     = s.awaddr;
          len_d      = s.awlen;
          size_d     = s.awsize;
          burst_d    = s.awburst;
          beat_cnt_d = 8'd0;
          err_d      = bad_req(s.awlen, s.awsize, s.awburst);
          werr_d     = 1'b0;
        end else if (s.arvalid && s.awvalid) begin
          // Contention: serve the kind that did not complete last.
          arready_d = rr_last_wr_q;
          awready_d = !rr_last_wr_q;
        end else begin
          arready_d = s.arvalid;
          awready_d = s.awvalid;
        end
      end
      RD_REQ: state_d = RD_DATA;
      RD_DATA: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d      = IDLE;
            rr_last_wr_d = 1'b0;
          end else begin
            state_d    = RD_REQ;
            addr_d     = next_addr;
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          addr_d     = next_addr;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (s.wlast != last_beat) werr_d = 1'b1;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d      = IDLE;
          rr_last_wr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction context registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      arready_q    <= 1'b0;
      awready_q    <= 1'b0;
      rr_last_wr_q <= 1'b1;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      werr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      arready_q    <= arready_d;
      awready_q    <= awready_d;
      rr_last_wr_q <= rr_last_wr_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      werr_q       <= werr_d;
    end
  end

  // AXI outputs; R fields come from registers plus the SRAM's held read data,
  // so they stay stable for as long as rready is low.
  always_comb begin
    s.arready = arready_q;
    s.awready = awready_q;
    s.rvalid  = (state_q == RD_DATA);
    s.rid     = id_q;
    s.rdata   = (s.rvalid && !err_q) ? sram_rdata : '0;
    s.rresp   = (s.rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    s.rlast   = s.rvalid && last_beat;
    s.wready  = (state_q == WR_DATA);
    s.bvalid  = (state_q == WR_RESP);
    s.bid     = id_q;
    s.bresp   = (s.bvalid && (err_q || werr_q)) ? RESP_SLVERR : RESP_OKAY;
  end

  // SRAM port: one read per RD_REQ, writes pass straight through from the W beat.
  always_comb begin
    sram_en    = (state_q == RD_REQ) || (w_hs && !err_q);
    sram_we    = (w_hs && !err_q) ? s.wstrb : '0;
    sram_addr  = addr_q[MEM_AW+1:2];
    sram_wdata = s.wdata;
  end

endmodule
